// File: rtl/lcd_pkg.sv
// Shared LCD read-path definitions: panel geometry, word format, FSM states.
package lcd_pkg;

    localparam int H_ACTIVE     = 480;
    localparam int V_ACTIVE     = 272;
    localparam int PIX_PER_WORD = 4;
    localparam int WORD_W       = 96;
    localparam int FRAME_WORDS  = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        WAIT,
        FLUSH
    } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO with occupancy count and synchronous clear.
// The head word reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (count != (AW+1)'(DEPTH));
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/lcd_rd_buf.sv
// LCD frame read buffer: fetches DDR bursts into a FWFT FIFO, one burst
// outstanding at a time, restarting from the frame base on each vsync fall.
module lcd_rd_buf
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int BURST_LEN   = 8,
    parameter int FRAME_WORDS = lcd_pkg::FRAME_WORDS,
    parameter int ADDR_W      = 24,
    parameter int BASE_ADDR   = 0
) (
    input  logic              lcd_clk,
    input  logic              lcd_rst_n,
    input  logic              ddr_init_done,
    input  logic              lcd_framesync,
    input  logic              ddr_rden,
    output logic [WORD_W-1:0] ddr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_data_valid,
    input  logic [WORD_W-1:0] rd_data,
    output logic              underflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WRW = $clog2(FRAME_WORDS + 1);
    localparam int BW  = $clog2(BURST_LEN + 1);

    rd_state_e        state;
    rd_state_e        state_nxt;
    logic             fs_q;
    logic             fs_fall;
    logic [WRW-1:0]   words_req;
    logic [WRW-1:0]   words_nxt;
    logic [BW-1:0]    beats;
    logic             discard;
    logic             last_beat;
    logic             space_ok;
    logic             more_ok;
    logic             push;
    logic             clr;
    logic [AW:0]      count;
    logic             empty;

    assign fs_fall   = fs_q & ~lcd_framesync;
    assign space_ok  = (DEPTH - int'(count)) >= BURST_LEN;
    assign more_ok   = int'(words_req) < FRAME_WORDS;
    assign last_beat = rd_data_valid && (beats == BW'(BURST_LEN - 1));
    assign rd_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(words_req);
    assign words_nxt = (int'(words_req) + BURST_LEN >= FRAME_WORDS)
                     ? WRW'(FRAME_WORDS)
                     : words_req + WRW'(BURST_LEN);

    always_ff @(posedge lcd_clk or negedge lcd_rst_n) begin
        if (!lcd_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (fs_fall)
                    state_nxt = FLUSH;
                else if (ddr_init_done)
                    state_nxt = CHECK;
            end
            CHECK: begin
                if (fs_fall)
                    state_nxt = FLUSH;
                else if (!ddr_init_done)
                    state_nxt = IDLE;
                else if (space_ok && more_ok)
                    state_nxt = REQ;
            end
            REQ: begin
                if (fs_fall)
                    state_nxt = FLUSH;
                else if (rd_ack)
                    state_nxt = WAIT;
                else if (!ddr_init_done)
                    state_nxt = IDLE;
            end
            WAIT: begin
                // the burst always drains fully so no stray beat leaks later
                if (last_beat) begin
                    if (discard || fs_fall)
                        state_nxt = FLUSH;
                    else if (!ddr_init_done)
                        state_nxt = IDLE;
                    else
                        state_nxt = CHECK;
                end
            end
            FLUSH:   state_nxt = CHECK;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_req = 1'b0;
        push   = 1'b0;
        clr    = 1'b0;
        unique case (state)
            REQ:     rd_req = ~fs_fall;
            WAIT:    push   = rd_data_valid & ~discard & ~fs_fall;
            FLUSH:   clr    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge lcd_clk or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            fs_q      <= 1'b1;
            words_req <= '0;
            beats     <= '0;
            discard   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            fs_q <= lcd_framesync;
            if (state == FLUSH)
                words_req <= '0;
            else if (state == REQ && rd_ack && !fs_fall)
                words_req <= words_nxt;
            if (state != WAIT)
                beats <= '0;
            else if (rd_data_valid)
                beats <= beats + 1'b1;
            if (state != WAIT)
                discard <= 1'b0;
            else if (fs_fall)
                discard <= 1'b1;
            if (state == FLUSH)
                underflow <= 1'b0;
            else if (ddr_rden && empty)
                underflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (lcd_clk),
        .rst_n (lcd_rst_n),
        .clr   (clr),
        .push  (push),
        .din   (rd_data),
        .pop   (ddr_rden),
        .dout  (ddr_data),
        .count (count),
        .empty (empty)
    );

endmodule

// File: tb/tb_lcd_rd_buf.sv
// Directed bench for lcd_rd_buf with a simple burst responder and an
// in-order consumer that tracks the expected frame word address.
module tb_lcd_rd_buf;

    localparam int BURST  = 8;
    localparam int FWORDS = 32640;

    logic        lcd_clk = 1'b0;
    logic        lcd_rst_n = 1'b0;
    logic        ddr_init_done = 1'b1;
    logic        lcd_framesync = 1'b1;
    logic        ddr_rden = 1'b0;
    logic [95:0] ddr_data;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic        ack_en = 1'b1;
    logic        rd_data_valid = 1'b0;
    logic [95:0] rd_data = '0;
    logic        underflow;

    int n_checks = 0;
    int n_fail = 0;
    int pending = 0;
    int base = 0;
    int burst_beats = 0;
    int reqs = 0;
    int last_addr = -1;
    int exp_addr = 0;
    int reqs_base = 0;

    typedef struct {
        int pops;
        int reqs;
        int last;
        int cnt;
    } vec_t;

    vec_t vecs[6];

    assign rd_ack = ack_en;

    always #5 lcd_clk = ~lcd_clk;

    lcd_rd_buf dut (
        .lcd_clk       (lcd_clk),
        .lcd_rst_n     (lcd_rst_n),
        .ddr_init_done (ddr_init_done),
        .lcd_framesync (lcd_framesync),
        .ddr_rden      (ddr_rden),
        .ddr_data      (ddr_data),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_ack        (rd_ack),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .underflow     (underflow)
    );

    function automatic logic [95:0] word(input int a);
        logic [23:0] x;
        x = 24'(a);
        return {x, x ^ 24'hA5A5A5, ~x, x + 24'd1};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_d(input string name, input logic [95:0] act,
                           input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_ack(input logic v);
        @(posedge lcd_clk);
        #1;
        ack_en = v;
    endtask

    // call at a negedge; pops n words in order, one per cycle when available
    task automatic pop_words(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (ddr_data == '0 && t < 100) begin
                ddr_rden = 1'b0;
                @(negedge lcd_clk);
                t++;
            end
            check_d("pop_data", ddr_data, word(exp_addr));
            ddr_rden = 1'b1;
            exp_addr++;
            @(negedge lcd_clk);
        end
        ddr_rden = 1'b0;
    endtask

    // burst responder: BURST beats back-to-back after each handshake
    initial begin
        forever begin
            @(negedge lcd_clk);
            if (pending > 0) begin
                rd_data_valid = 1'b1;
                rd_data = word(base + burst_beats);
                burst_beats++;
                pending--;
            end else begin
                rd_data_valid = 1'b0;
            end
            if (rd_req && rd_ack) begin
                pending = BURST;
                base = int'(rd_addr);
                burst_beats = 0;
                reqs++;
                last_addr = int'(rd_addr);
            end
        end
    end

    initial begin
        int t;
        vecs[0] = '{0, 2, 8, 16};
        vecs[1] = '{8, 3, 16, 16};
        vecs[2] = '{7, 3, 16, 9};
        vecs[3] = '{1, 4, 24, 16};
        vecs[4] = '{12, 5, 32, 12};
        vecs[5] = '{4, 6, 40, 16};

        repeat (3) @(negedge lcd_clk);
        check("rst_rd_req", int'(rd_req), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check_d("rst_ddr_data", ddr_data, '0);
        check("rst_underflow", int'(underflow), 0);
        lcd_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            pop_words(vecs[i].pops);
            repeat (30) @(negedge lcd_clk);
            check("vec_reqs", reqs, vecs[i].reqs);
            check("vec_last_addr", last_addr, vecs[i].last);
            check("vec_count", int'(dut.u_fifo.count), vecs[i].cnt);
            check("vec_rd_req_idle", int'(rd_req), 0);
        end

        // push and pop in the same cycle at DEPTH-1
        pop_words(8);
        t = 0;
        while (int'(dut.u_fifo.count) != 15 && t < 40) begin
            @(negedge lcd_clk);
            t++;
        end
        check("pp_reach_15", int'(dut.u_fifo.count), 15);
        check_d("pp_head", ddr_data, word(exp_addr));
        ddr_rden = 1'b1;
        exp_addr++;
        @(negedge lcd_clk);
        ddr_rden = 1'b0;
        check("pp_count", int'(dut.u_fifo.count), 15);
        repeat (20) @(negedge lcd_clk);
        check("pp_count_hold", int'(dut.u_fifo.count), 15);
        check("pp_last_addr", last_addr, 48);

        // drain with requests stalled, then pop while empty
        set_ack(1'b0);
        @(negedge lcd_clk);
        pop_words(15);
        repeat (3) @(negedge lcd_clk);
        check("stall_rd_req", int'(rd_req), 1);
        check("stall_rd_addr", int'(rd_addr), 56);
        check_d("empty_data", ddr_data, '0);
        check("empty_rd_ptr", int'(dut.u_fifo.rd_ptr), 8);
        check("pre_underflow", int'(underflow), 0);
        ddr_rden = 1'b1;
        @(negedge lcd_clk);
        ddr_rden = 1'b0;
        check("uf_set", int'(underflow), 1);
        check_d("uf_data", ddr_data, '0);
        check("uf_rd_ptr", int'(dut.u_fifo.rd_ptr), 8);
        repeat (10) @(negedge lcd_clk);
        check("uf_sticky", int'(underflow), 1);

        // framesync in REQ flushes immediately
        lcd_framesync = 1'b0;
        @(negedge lcd_clk);
        lcd_framesync = 1'b1;
        repeat (3) @(negedge lcd_clk);
        check("fs_uf_clear", int'(underflow), 0);
        check("fs_rd_req", int'(rd_req), 1);
        check("fs_rd_addr", int'(rd_addr), 0);
        check("fs_count", int'(dut.u_fifo.count), 0);
        exp_addr = 0;

        // framesync after 3 beats: rest of burst discarded
        set_ack(1'b1);
        t = 0;
        while (burst_beats != 3 && t < 30) begin
            @(posedge lcd_clk);
            t++;
        end
        @(negedge lcd_clk);
        lcd_framesync = 1'b0;
        set_ack(1'b0);
        @(negedge lcd_clk);
        lcd_framesync = 1'b1;
        t = 0;
        while (burst_beats != 8 && t < 30) begin
            @(posedge lcd_clk);
            t++;
        end
        #1;
        check("disc_count", int'(dut.u_fifo.count), 3);
        check_d("disc_head", ddr_data, word(0));
        repeat (4) @(negedge lcd_clk);
        check("disc_flush_count", int'(dut.u_fifo.count), 0);
        check_d("disc_flush_data", ddr_data, '0);
        check("disc_rd_req", int'(rd_req), 1);
        check("disc_rd_addr", int'(rd_addr), 0);

        // one whole frame
        reqs_base = reqs;
        exp_addr = 0;
        set_ack(1'b1);
        @(negedge lcd_clk);
        pop_words(FWORDS);
        repeat (50) @(negedge lcd_clk);
        check("frame_bursts", reqs - reqs_base, FWORDS / BURST);
        check("frame_last_addr", last_addr, 32632);
        check("frame_no_req", int'(rd_req), 0);
        check_d("frame_empty", ddr_data, '0);
        set_ack(1'b0);
        @(negedge lcd_clk);
        lcd_framesync = 1'b0;
        @(negedge lcd_clk);
        lcd_framesync = 1'b1;
        repeat (3) @(negedge lcd_clk);
        check("next_frame_req", int'(rd_req), 1);
        check("next_frame_addr", int'(rd_addr), 0);

        // init_done drop: burst completes, then back to IDLE
        reqs_base = reqs;
        exp_addr = 0;
        set_ack(1'b1);
        ddr_init_done = 1'b0;
        repeat (30) @(negedge lcd_clk);
        check("init_bursts", reqs - reqs_base, 1);
        check("init_count", int'(dut.u_fifo.count), 8);
        check("init_no_req", int'(rd_req), 0);
        pop_words(8);
        repeat (10) @(negedge lcd_clk);
        check("init_idle_req", int'(rd_req), 0);
        ddr_init_done = 1'b1;
        repeat (40) @(negedge lcd_clk);
        check("init_resume_addr", last_addr, 16);
        check("init_resume_count", int'(dut.u_fifo.count), 16);

        // reset in the middle of a burst
        pop_words(8);
        t = 0;
        while (burst_beats != 2 && t < 30) begin
            @(posedge lcd_clk);
            t++;
        end
        @(negedge lcd_clk);
        ack_en = 1'b0;
        lcd_rst_n = 1'b0;
        repeat (2) @(negedge lcd_clk);
        lcd_rst_n = 1'b1;
        t = 0;
        while (pending != 0 && t < 20) begin
            @(negedge lcd_clk);
            t++;
        end
        repeat (5) @(negedge lcd_clk);
        check("mrst_count", int'(dut.u_fifo.count), 0);
        check_d("mrst_data", ddr_data, '0);
        check("mrst_rd_req", int'(rd_req), 1);
        check("mrst_rd_addr", int'(rd_addr), 0);
        check("mrst_underflow", int'(underflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
